// File: rtl/ticket_change_dispenser.sv
// ticket_change_dispenser: issues tickets one at a time, then pays change greedily in 50/10/5/1 coins.
module ticket_change_dispenser #(
  parameter int MW = 8,
  parameter int TW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [TW-1:0] tickets,
  input  logic [MW-1:0] change,
  output logic          ticket_valid,
  input  logic          ticket_ack,
  output logic          coin_valid,
  output logic [1:0]    coin_sel,
  input  logic          coin_ack,
  output logic          busy,
  output logic          done,
  output logic [3:0]    coins_out
);
  typedef enum logic [1:0] {IDLE, TICKET, COIN, DONE} state_t;
  state_t        state_q, state_d;
  logic [TW-1:0] tkt_q, tkt_d;
  logic [MW-1:0] chg_q, chg_d, den;
  logic [3:0]    cnt_q, cnt_d;
  logic [1:0]    sel;
  // Denomination is decoded from the registered remainder, so it cannot glitch during a stall.
  always_comb begin
    sel = chg_q >= MW'(50) ? 2'b11 : chg_q >= MW'(10) ? 2'b10 : chg_q >= MW'(5) ? 2'b01 : 2'b00;
    den = sel == 2'b11 ? MW'(50) : sel == 2'b10 ? MW'(10) : sel == 2'b01 ? MW'(5) : MW'(1);
  end
  always_comb begin
    state_d = state_q;
    tkt_d   = tkt_q;
    chg_d   = chg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        tkt_d   = tickets;
        chg_d   = change;
        cnt_d   = 4'd0;
        state_d = tickets != '0 ? TICKET : change != '0 ? COIN : DONE;
      end
      TICKET: if (ticket_ack) begin
        tkt_d = tkt_q - TW'(1);
        if (tkt_q == TW'(1)) state_d = chg_q != '0 ? COIN : DONE;
      end
      COIN: if (coin_ack) begin
        chg_d = chg_q - den;
        cnt_d = cnt_q == 4'hf ? cnt_q : cnt_q + 4'd1;
        if (chg_q == den) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tkt_q   <= '0;
      chg_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tkt_q   <= tkt_d;
      chg_q   <= chg_d;
      cnt_q   <= cnt_d;
    end
  end
  assign ticket_valid = state_q == TICKET;
  assign coin_valid   = state_q == COIN;
  assign coin_sel     = coin_valid ? sel : 2'b00;
  assign busy         = state_q != IDLE;
  assign done         = state_q == DONE;
  assign coins_out    = cnt_q;
endmodule

// File: tb/tb_ticket_change_dispenser.sv
// tb_ticket_change_dispenser: directed and random transactions checked against a queue-based model.
module tb_ticket_change_dispenser;
  localparam int MW = 8;
  localparam int TW = 3;
  logic          clk = 1'b0, reset = 1'b0, start = 1'b0, ticket_ack = 1'b0, coin_ack = 1'b0;
  logic [TW-1:0] tickets = '0;
  logic [MW-1:0] change = '0;
  logic          ticket_valid, coin_valid, busy, done;
  logic [1:0]    coin_sel;
  logic [3:0]    coins_out;
  int checks = 0, failures = 0;
  bit m_busy;
  int m_tk, m_cnt, stall;
  int coins[$];
  bit e_tv, e_cv, e_done;
  int e_sel;

  ticket_change_dispenser #(.MW(MW), .TW(TW)) dut (
    .clk(clk), .reset(reset), .start(start), .tickets(tickets), .change(change),
    .ticket_valid(ticket_valid), .ticket_ack(ticket_ack), .coin_valid(coin_valid),
    .coin_sel(coin_sel), .coin_ack(coin_ack), .busy(busy), .done(done), .coins_out(coins_out)
  );

  always #5 clk = ~clk;

  function automatic int code(int d);
    return d == 50 ? 3 : d == 10 ? 2 : d == 5 ? 1 : 0;
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic calc();
    e_tv   = m_busy && m_tk > 0;
    e_cv   = m_busy && m_tk == 0 && coins.size() > 0;
    e_sel  = e_cv ? code(coins[0]) : 0;
    e_done = m_busy && m_tk == 0 && coins.size() == 0;
  endtask

  task automatic check_outputs();
    calc();
    chk("ticket_valid", 8'(ticket_valid), 8'(e_tv));
    chk("coin_valid", 8'(coin_valid), 8'(e_cv));
    chk("coin_sel", 8'(coin_sel), 8'(e_sel));
    chk("busy", 8'(busy), 8'(m_busy));
    chk("done", 8'(done), 8'(e_done));
    chk("coins_out", 8'(coins_out), 8'(m_cnt));
  endtask

  task automatic load(int tk, int chg);
    int c, d;
    m_busy = 1;
    m_tk   = tk;
    m_cnt  = 0;
    coins.delete();
    c = chg;
    while (c > 0) begin
      d = c >= 50 ? 50 : c >= 10 ? 10 : c >= 5 ? 5 : 1;
      coins.push_back(d);
      c -= d;
    end
  endtask

  task automatic step(bit s, int tk, int chg, bit ta, bit ca);
    @(negedge clk);
    check_outputs();
    start = s; tickets = TW'(tk); change = MW'(chg); ticket_ack = ta; coin_ack = ca;
    if (!m_busy) begin
      if (s) load(tk, chg);
    end else if (e_tv) begin
      if (ta) m_tk--;
    end else if (e_cv) begin
      if (ca) begin
        void'(coins.pop_front());
        m_cnt = m_cnt < 15 ? m_cnt + 1 : 15;
      end
    end else m_busy = 0;
  endtask

  // mode 0: acks held high; 1: random acks and random start re-pulses;
  // 2: coin_ack stalls 2 cycles on the first 50 coin; 3: start re-pulsed (5,20) during COIN.
  task automatic run(int tk, int chg, int mode, int abort_at);
    bit ta, ca, rs;
    step(1, tk, chg, 0, 0);
    stall = 0;
    for (int n = 0; n < 300 && m_busy; n++) begin
      calc();
      if (abort_at >= 0 && m_cnt == abort_at && e_cv) begin
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        m_busy = 0; m_tk = 0; m_cnt = 0; coins.delete();
        #1;
        check_outputs();
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      ta = mode == 1 ? 1'($urandom % 2) : 1'b1;
      ca = mode == 1 ? 1'($urandom % 2) : 1'b1;
      rs = mode == 1 ? 1'($urandom % 2) : 1'b0;
      if (mode == 2 && e_sel == 3 && stall < 2) begin
        ca = 1'b0;
        stall++;
      end
      if (mode == 3 && e_cv) step(1, 5, 20, ta, ca);
      else step(rs, int'($urandom % 8), int'($urandom % 256), ta, ca);
    end
    chk("timeout", 8'(m_busy), 8'd0);
  endtask

  initial begin
    m_busy = 0; m_tk = 0; m_cnt = 0;
    @(negedge clk);
    check_outputs();
    reset = 1'b1;
    run(2, 0, 0, -1);
    run(0, 38, 0, -1);
    run(3, 63, 2, -1);
    run(0, 0, 0, -1);
    run(1, 20, 3, -1);
    run(0, 55, 0, 1);
    run(0, 5, 0, -1);
    run(7, 255, 0, -1);
    run(0, 49, 1, -1);
    for (int i = 0; i < 25; i++) run(int'($urandom % 8), int'($urandom % 256), 1, -1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ticket_change_dispenser.md
Name: ticket_change_dispenser

Overview:
Output stage placed directly downstream of vending_machine. When a sale completes, it takes the ticket count and the change owed, then drives the ticket printer and the coin hopper. Tickets are issued one at a time over a valid/ack handshake. Change is paid greedily in 50/10/5/1 coins over a second valid/ack handshake. A one-cycle done pulse marks the end of each transaction.

Parameters:
MW, 8, width of change amount and coin-value arithmetic (max change 2^MW-1)
TW, 3, width of ticket count (matches howmanyticket)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  one-cycle request; samples tickets/change; ignored unless idle
tickets  input  TW  number of tickets to issue
change  input  MW  change to return, in coin units of 1
ticket_valid  output  1  a ticket is offered to the printer
ticket_ack  input  1  printer accepts the offered ticket this cycle
coin_valid  output  1  a coin is offered to the hopper
coin_sel  output  2  denomination offered: 00=1, 01=5, 10=10, 11=50
coin_ack  input  1  hopper accepts the offered coin this cycle
busy  output  1  transaction in progress (state != IDLE)
done  output  1  one-cycle pulse at end of transaction
coins_out  output  4  coins paid in the current/last transaction (saturates at 15)

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0: ticket_valid, coin_valid, coin_sel=00, busy, done, coins_out.
  - Internal tkt_left and chg_left are 0.
  - Reset mid-transaction abandons it immediately. No done pulse is produced.
- All outputs are registered or decoded from registered state. No combinational path from any input to any output.
- State machine:
  - IDLE, start=1: latch tkt_left=tickets, chg_left=change, clear coins_out.
    - tickets!=0: next state is TICKET.
    - tickets=0 and change!=0: next state is COIN.
    - Otherwise: next state is DONE.
  - TICKET: ticket_valid=1.
    - Each cycle with ticket_ack=1 decrements tkt_left.
    - On the ack that takes tkt_left to 0, go to COIN if chg_left!=0, else DONE.
    - ticket_valid stays high between back-to-back tickets.
    - ticket_ack is ignored outside TICKET.
  - COIN: coin_valid=1. coin_sel is the largest denomination <= chg_left (50, then 10, then 5, then 1).
    - coin_sel is stable while coin_valid=1 and coin_ack=0.
    - On coin_ack: chg_left -= denomination; coins_out += 1 (saturating at 15).
    - If the new chg_left is 0, go to DONE; otherwise stay in COIN and re-select the denomination next cycle.
    - coin_ack is ignored outside COIN.
  - DONE: done=1 for exactly one cycle; busy=1; next state is IDLE.
- start is ignored in every state except IDLE, including the DONE cycle.
- Latency:
  - The first ticket_valid or coin_valid is asserted in the cycle after start is sampled.
  - done is asserted in the cycle after the final ack.
  - A zero transaction asserts done in the cycle after start.
- Arithmetic: the subtraction never underflows, because the selected denomination is always <= chg_left. The comparison against 50 must work for every MW >= 6.
- coins_out holds its value in IDLE until the next accepted start.

Test Plan:
1. tickets=2, change=0; ticket_ack held at 1 → ticket_valid high for exactly 2 cycles, no coin_valid, done pulses on the 3rd cycle after start, coins_out=0.
2. tickets=0, change=38; coin_ack held at 1 → coin_sel sequence 10,10,10,5,1,1,1; coins_out=7; done pulses one cycle after the 7th ack.
3. tickets=3, change=63; ack stalls inserted (coin_ack low 2 cycles while coin_sel=11) → tickets first, then coins 50,10,1,1,1; coin_sel holds at 11 during the stall; coins_out=5.
4. tickets=0, change=0 → done pulses the cycle after start; ticket_valid and coin_valid never assert.
5. start re-pulsed with tickets=5, change=20 while in COIN → ignored; the original transaction completes with its own values.
6. reset driven to 0 mid-COIN (change=55, after the 50 coin) → all outputs 0 immediately, no done pulse; after release, start with change=5 → single coin_sel=01, coins_out=1.
